// File: rtl/multiport_register_file.sv
// Parametrised register file with two write ports, optional write-to-read bypass,
// and a per-register busy scoreboard that the hazard unit uses to stall.
module multiport_register_file #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned ADDR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W   = ADDR_W + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr0_en,
  input  logic [ADDR_W-1:0]          wr0_addr,
  input  logic [DATA_W-1:0]          wr0_data,
  input  logic                       wr1_en,
  input  logic [ADDR_W-1:0]          wr1_addr,
  input  logic [DATA_W-1:0]          wr1_data,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  output logic [CNT_W-1:0]           busy_cnt
);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0]  busy_cnt_q, busy_cnt_d;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  // Port 1 is applied after port 0 so it wins on a shared address; reserve is last so a
  // new producer keeps the register busy even while an older result is written.
  always_comb begin
    regs_d     = regs_q;
    busy_d     = busy_q;
    busy_cnt_d = '0;
    if (wr0_en && !is_zero(wr0_addr)) begin
      regs_d[wr0_addr] = wr0_data;
      busy_d[wr0_addr] = 1'b0;
    end
    if (wr1_en && !is_zero(wr1_addr)) begin
      regs_d[wr1_addr] = wr1_data;
      busy_d[wr1_addr] = 1'b0;
    end
    if (rsv_en && !is_zero(rsv_addr)) begin
      busy_d[rsv_addr] = 1'b1;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      busy_cnt_d = busy_cnt_d + CNT_W'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rdat;
  logic              rbsy;

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    rdat    = '0;
    rbsy    = 1'b0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      ra   = rd_addr[k*ADDR_W +: ADDR_W];
      rdat = regs_q[ra];
      rbsy = busy_q[ra];
      if (BYPASS) begin
        if (wr0_en && (wr0_addr == ra)) begin
          rdat = wr0_data;
          rbsy = 1'b0;
        end
        if (wr1_en && (wr1_addr == ra)) begin
          rdat = wr1_data;
          rbsy = 1'b0;
        end
      end
      // Gating on reset keeps a bypassed write from leaking out while reset is held.
      if (is_zero(ra) || !reset) begin
        rdat = '0;
        rbsy = 1'b0;
      end
      rd_data[k*DATA_W +: DATA_W] = rdat;
      rd_busy[k]                  = rbsy;
    end
  end

  assign busy_cnt = busy_cnt_q;

endmodule
